agnus_sprite_dma_sequencer: RTL and testbench
=============================================

AGNUS_SPRITE_DMA_SEQUENCER -- requirements
Module: agnus_sprite_dma_sequencer

Interface
REQ-001 Parameter SPR_BASE, default 9'h015: DMA cycle (hpos) of sprite 0, slot 0.
REQ-002 Parameter VSPR_LINE, default 9'd25: line on which all sprites restart control fetches.
REQ-003 clk  in  1  28 MHz system clock; all state advances only on cycles with clk7_en=1.
REQ-004 reset_n  in  1  synchronous, active-low reset; one clock; sampled on every clk edge, regardless of clk7_en.
REQ-005 clk7_en  in  1  7 MHz clock enable.
REQ-006 hpos  in  9  horizontal DMA cycle counter.
REQ-007 vpos  in  9  vertical line counter.
REQ-008 dmaen  in  1  sprite DMA enable (DMACON SPREN and DMAEN).
REQ-009 ptr_wr  in  1  pointer register write strobe.
REQ-010 ptr_sel  in  4  {sprite[2:0], hi}; hi=1 selects ptr[20:16], hi=0 selects ptr[15:1].
REQ-011 ptr_data  in  16  pointer write data.
REQ-012 dma_req  out  1  bus request for the current slot.
REQ-013 dma_addr  out  20  chip word address [20:1] of the request.
REQ-014 dma_ack  in  1  grant, valid in the same clk7_en cycle as dma_req.
REQ-015 chip_data  in  16  fetched word, valid on the clk7_en following an acked request.
REQ-016 spr_wr  out  1  Denise sprite register write strobe, one clk7_en cycle wide.
REQ-017 spr_num  out  3  target sprite.
REQ-018 spr_reg  out  2  00 POS, 01 CTL, 10 DATA, 11 DATB.
REQ-019 spr_data  out  16  register write data (equals captured chip_data).

Function
REQ-020 Sprite n shall own slot0 at hpos=SPR_BASE+4n and slot1 at hpos=SPR_BASE+4n+2, for n=0..7.
REQ-021 dma_req shall assert only when clk7_en=1, hpos matches an owned slot, dmaen=1, and the owner is in CTRL, or in DATA with vpos!=vstop; otherwise it is 0.
REQ-022 dma_addr shall equal the owner's 20-bit pointer while dma_req=1; otherwise it is 0.
REQ-023 On an acked slot, the pointer shall increment by one word, with 20-bit wrap-around from 0xFFFFF to 0.
REQ-024 An unacked slot shall be lost: no pointer change, no state change, no spr_wr.
REQ-025 Each sprite shall have one state: IDLE, CTRL, WAIT, DATA.
REQ-026 CTRL: slot0 fetches POS and slot1 fetches CTL. After the CTL write the sprite goes to DONE (held in IDLE) if POS=CTL=0; otherwise it goes to WAIT.
REQ-027 vstart = {CTL[2], POS[15:8]}; vstop = {CTL[1], CTL[15:8]}; both latched internally on the POS/CTL writes.
REQ-028 WAIT: no fetches; move to DATA when vpos==vstart, checked at slot0 time of that line.
REQ-029 DATA, vpos!=vstop: slot0 fetches DATB and slot1 fetches DATA, so that the DATA write (which arms the sprite) comes last.
REQ-030 DATA, vpos==vstop: the sprite behaves as CTRL on that line and fetches the next POS/CTL pair (sprite reuse).
REQ-031 The spr_wr/spr_reg/spr_num/spr_data write shall occur exactly one clk7_en cycle after the acked request; latency is 1.
REQ-032 When clk7_en=1, hpos==0 and vpos==VSPR_LINE, all sprites shall enter CTRL; this overrides any other state.
REQ-033 ptr_wr updates the selected half only. If ptr_wr targets the same sprite in the same cycle as an ack, the written value wins and no increment is applied.
REQ-034 vstart==vstop shall yield zero DATA lines: the sprite refetches CTL on that line.
REQ-035 dmaen=0 shall freeze all states and pointers; a fetch already acked still completes its spr_wr.
REQ-036 At most one request may be outstanding; slots are disjoint by construction.

Reset
REQ-037 On reset_n=0: all states IDLE; pointers, vstart and vstop 0; dma_req, spr_wr, spr_num, spr_reg, spr_data 0; any pending capture cancelled.
REQ-038 Reset asserted mid-fetch shall suppress the pending spr_wr.

Verification
REQ-039 ptr0=0x01000, line 25, acks always -> req at hpos 0x15 and 0x17 with addr 0x01000 and 0x01001; POS then CTL written to sprite 0; ptr0=0x01002.
REQ-040 POS=0x3040, CTL=0x3200 -> sprite 0 in WAIT until vpos=0x30; then DATB and DATA fetched on lines 0x30..0x31; POS/CTL refetched on line 0x32.
REQ-041 POS=CTL=0 fetched -> no further sprite 0 requests until the next line 25.
REQ-042 dma_ack=0 at hpos 0x19 (sprite 1, slot 0) -> no spr_wr, ptr1 unchanged; sprite 1 retries on the next line.
REQ-043 ptr_wr to sprite 2 low half with data 0x2000 in the same cycle as its ack -> ptr2[15:1]=0x2000, no increment.
REQ-044 reset_n low for one clk during the capture cycle -> spr_wr stays 0; all outputs 0.

Source files
------------

// File: rtl/agnus_sprite_dma_sequencer_if.sv
// Bus bundle between the sprite DMA sequencer, the chip-bus arbiter,
// the CPU register port and the Denise sprite register file.
interface agnus_sprite_dma_sequencer_if;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        dmaen;
  logic        ptr_wr;
  logic [3:0]  ptr_sel;
  logic [15:0] ptr_data;
  logic        dma_req;
  logic [19:0] dma_addr;
  logic        dma_ack;
  logic [15:0] chip_data;
  logic        spr_wr;
  logic [2:0]  spr_num;
  logic [1:0]  spr_reg;
  logic [15:0] spr_data;

  modport master (
    input  hpos, vpos, dmaen, ptr_wr, ptr_sel, ptr_data, dma_ack, chip_data,
    output dma_req, dma_addr, spr_wr, spr_num, spr_reg, spr_data
  );

  modport slave (
    output hpos, vpos, dmaen, ptr_wr, ptr_sel, ptr_data, dma_ack, chip_data,
    input  dma_req, dma_addr, spr_wr, spr_num, spr_reg, spr_data
  );
endinterface

// File: rtl/agnus_sprite_dma_sequencer.sv
// Sprite DMA sequencer: eight sprites, two fixed DMA slots each per line.
// Fetches POS/CTL control words and DATB/DATA image words, forwards them to
// Denise one clk7_en cycle after the bus grant.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no fetches (also the "done" state after a POS=CTL=0 pair)
// CTRL   | slot0 fetches POS, slot1 fetches CTL
// WAIT   | no fetches; leaves for DATA at slot0 of line vpos==vstart
// DATA   | slot0 DATB, slot1 DATA; on line vstop behaves as CTRL (reuse)
module agnus_sprite_dma_sequencer #(
  parameter logic [8:0] SPR_BASE  = 9'h015,
  parameter logic [8:0] VSPR_LINE = 9'd25
) (
  input logic                          clk,
  input logic                          reset_n,
  input logic                          clk7_en,
  agnus_sprite_dma_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CTRL = 2'd1,
    S_WAIT = 2'd2,
    S_DATA = 2'd3
  } spr_state_e;

  localparam logic [1:0] REG_POS  = 2'b00;
  localparam logic [1:0] REG_CTL  = 2'b01;
  localparam logic [1:0] REG_DATA = 2'b10;
  localparam logic [1:0] REG_DATB = 2'b11;

  spr_state_e  state_q  [8];
  spr_state_e  state_d  [8];
  logic [19:0] ptr_q    [8];
  logic [19:0] ptr_d    [8];
  logic [8:0]  vstart_q [8];
  logic [8:0]  vstart_d [8];
  logic [8:0]  vstop_q  [8];
  logic [8:0]  vstop_d  [8];
  logic [7:0]  pos_zero_q, pos_zero_d;

  logic        pend_q, pend_d;
  logic [2:0]  pend_num_q, pend_num_d;
  logic [1:0]  pend_reg_q, pend_reg_d;

  logic [8:0]  slot_off;
  logic        slot_hit;
  logic        slot1;
  logic [2:0]  slot_num;
  logic        eff_data;
  logic        ctrl_mode;
  logic        data_mode;
  logic        req;
  logic        acked;
  logic [1:0]  fetch_reg;
  logic [19:0] ptr_tmp;
  logic [2:0]  wr_num;

  // Slot ownership and fetch decision for the sprite owning this hpos
  always_comb begin
    slot_off  = bus.hpos - SPR_BASE;
    slot_hit  = (bus.hpos >= SPR_BASE) && (slot_off < 9'd32) && !slot_off[0];
    slot1     = slot_off[1];
    slot_num  = slot_off[4:2];
    // WAIT turns into DATA at slot0 of the start line, and that slot already fetches
    eff_data  = (state_q[slot_num] == S_DATA) ||
                ((state_q[slot_num] == S_WAIT) && !slot1 &&
                 (bus.vpos == vstart_q[slot_num]));
    ctrl_mode = (state_q[slot_num] == S_CTRL) ||
                (eff_data && (bus.vpos == vstop_q[slot_num]));
    data_mode = eff_data && (bus.vpos != vstop_q[slot_num]);
    req       = clk7_en && slot_hit && bus.dmaen && (ctrl_mode || data_mode);
    acked     = req && bus.dma_ack;
    if (ctrl_mode) fetch_reg = slot1 ? REG_CTL : REG_POS;
    else           fetch_reg = slot1 ? REG_DATA : REG_DATB;
  end

  // Next-state: per-sprite FSMs, pointers, latched vstart/vstop, capture pipe
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      state_d[i]  = state_q[i];
      ptr_d[i]    = ptr_q[i];
      vstart_d[i] = vstart_q[i];
      vstop_d[i]  = vstop_q[i];
    end
    pos_zero_d = pos_zero_q;
    pend_d     = pend_q;
    pend_num_d = pend_num_q;
    pend_reg_d = pend_reg_q;
    ptr_tmp    = '0;
    wr_num     = bus.ptr_sel[3:1];

    if (clk7_en) begin
      pend_d = acked;
      if (acked) begin
        pend_num_d = slot_num;
        pend_reg_d = fetch_reg;
      end

      if (pend_q) begin
        if (pend_reg_q == REG_POS) begin
          vstart_d[pend_num_q][7:0]  = bus.chip_data[15:8];
          pos_zero_d[pend_num_q]     = (bus.chip_data == 16'h0000);
        end else if (pend_reg_q == REG_CTL) begin
          vstart_d[pend_num_q][8]    = bus.chip_data[2];
          vstop_d[pend_num_q]        = {bus.chip_data[1], bus.chip_data[15:8]};
          state_d[pend_num_q]        = (pos_zero_q[pend_num_q] && (bus.chip_data == 16'h0000))
                                       ? S_IDLE : S_WAIT;
        end
      end

      if (slot_hit && bus.dmaen && !slot1 && (state_q[slot_num] == S_WAIT) &&
          (bus.vpos == vstart_q[slot_num]))
        state_d[slot_num] = S_DATA;

      if (acked)
        ptr_d[slot_num] = ptr_q[slot_num] + 20'd1;

      // CPU write replaces the increment for the same sprite
      if (bus.ptr_wr) begin
        ptr_tmp = ptr_q[wr_num];
        if (bus.ptr_sel[0]) ptr_tmp[19:15] = bus.ptr_data[4:0];
        else                ptr_tmp[14:0]  = bus.ptr_data[15:1];
        ptr_d[wr_num] = ptr_tmp;
      end

      if ((bus.hpos == 9'd0) && (bus.vpos == VSPR_LINE)) begin
        for (int i = 0; i < 8; i++) state_d[i] = S_CTRL;
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        state_q[i]  <= S_IDLE;
        ptr_q[i]    <= '0;
        vstart_q[i] <= '0;
        vstop_q[i]  <= '0;
      end
      pos_zero_q <= '0;
      pend_q     <= 1'b0;
      pend_num_q <= '0;
      pend_reg_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        state_q[i]  <= state_d[i];
        ptr_q[i]    <= ptr_d[i];
        vstart_q[i] <= vstart_d[i];
        vstop_q[i]  <= vstop_d[i];
      end
      pos_zero_q <= pos_zero_d;
      pend_q     <= pend_d;
      pend_num_q <= pend_num_d;
      pend_reg_q <= pend_reg_d;
    end
  end

  assign bus.dma_req  = req;
  assign bus.dma_addr = req ? ptr_q[slot_num] : 20'h00000;
  assign bus.spr_wr   = pend_q;
  assign bus.spr_num  = pend_q ? pend_num_q : 3'd0;
  assign bus.spr_reg  = pend_q ? pend_reg_q : 2'd0;
  assign bus.spr_data = pend_q ? bus.chip_data : 16'h0000;

endmodule

// File: tb/tb_agnus_sprite_dma_sequencer.sv
// Directed vector bench for the sprite DMA sequencer.
module tb_agnus_sprite_dma_sequencer;

  logic clk;
  logic reset_n;
  logic clk7_en;

  agnus_sprite_dma_sequencer_if bus ();

  agnus_sprite_dma_sequencer #(
    .SPR_BASE  (9'h015),
    .VSPR_LINE (9'd25)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  h;
    logic [8:0]  v;
    logic        dmaen;
    logic        ack;
    logic [15:0] cd;
    logic        pw;
    logic [3:0]  psel;
    logic [15:0] pd;
    logic        req;
    logic [19:0] addr;
    logic        wr;
    logic [2:0]  num;
    logic [1:0]  rg;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [8:0] h, input logic [8:0] v, input logic ack,
                              input logic [15:0] cd, input logic req, input logic [19:0] addr,
                              input logic wr, input logic [2:0] num, input logic [1:0] rg,
                              input logic [15:0] data);
    vec_t t;
    t.h = h; t.v = v; t.dmaen = 1'b1; t.ack = ack; t.cd = cd;
    t.pw = 1'b0; t.psel = 4'h0; t.pd = 16'h0000;
    t.req = req; t.addr = addr; t.wr = wr; t.num = num; t.rg = rg; t.data = data;
    return t;
  endfunction

  function automatic vec_t pv(input logic [3:0] psel, input logic [15:0] pd);
    vec_t t;
    t = mk(9'h1FF, 9'h1FF, 1'b0, 16'h0, 1'b0, 20'h0, 1'b0, 3'd0, 2'd0, 16'h0);
    t.pw = 1'b1; t.psel = psel; t.pd = pd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    bus.hpos      = t.h;
    bus.vpos      = t.v;
    bus.dmaen     = t.dmaen;
    bus.dma_ack   = t.ack;
    bus.chip_data = t.cd;
    bus.ptr_wr    = t.pw;
    bus.ptr_sel   = t.psel;
    bus.ptr_data  = t.pd;
    clk7_en       = 1'b1;
    #1;
    chk($sformatf("v%0d dma_req", idx),  {31'd0, bus.dma_req},  {31'd0, t.req});
    chk($sformatf("v%0d dma_addr", idx), {12'd0, bus.dma_addr}, {12'd0, t.addr});
    chk($sformatf("v%0d spr_wr", idx),   {31'd0, bus.spr_wr},   {31'd0, t.wr});
    chk($sformatf("v%0d spr_num", idx),  {29'd0, bus.spr_num},  {29'd0, t.num});
    chk($sformatf("v%0d spr_reg", idx),  {30'd0, bus.spr_reg},  {30'd0, t.rg});
    chk($sformatf("v%0d spr_data", idx), {16'd0, bus.spr_data}, {16'd0, t.data});
    @(negedge clk);
    clk7_en     = 1'b0;
    bus.dma_ack = 1'b0;
    bus.ptr_wr  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    reset_n = 1'b0; clk7_en = 1'b0;
    bus.hpos = '0; bus.vpos = '0; bus.dmaen = 1'b1; bus.dma_ack = 1'b0;
    bus.chip_data = '0; bus.ptr_wr = 1'b0; bus.ptr_sel = '0; bus.ptr_data = '0;

    // ptr0 = 0x01000, ptr3 = 0xFFFFF
    vecs.push_back(pv(4'b0000, 16'h2000));
    vecs.push_back(pv(4'b0111, 16'h001F));
    vecs.push_back(pv(4'b0110, 16'hFFFE));
    vecs.push_back(mk(9'h015, 9'h1FF, 1, 16'h0, 0, 20'h0, 0, 0, 0, 16'h0));
    // line 25: control fetches
    vecs.push_back(mk(9'h000, 9'd25, 0, 16'h0,    0, 20'h0,     0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h015, 9'd25, 1, 16'h0,    1, 20'h01000, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h016, 9'd25, 0, 16'h3040, 0, 20'h0,     1, 0, 0, 16'h3040));
    vecs.push_back(mk(9'h017, 9'd25, 1, 16'h0,    1, 20'h01001, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h018, 9'd25, 0, 16'h3200, 0, 20'h0,     1, 0, 1, 16'h3200));
    vecs.push_back(mk(9'h019, 9'd25, 0, 16'h0,    1, 20'h0,     0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h01A, 9'd25, 0, 16'h1234, 0, 20'h0,     0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h01B, 9'd25, 0, 16'h0,    1, 20'h0,     0, 0, 0, 16'h0));
    t = mk(9'h01D, 9'd25, 1, 16'h0, 1, 20'h0, 0, 0, 0, 16'h0);
    t.pw = 1'b1; t.psel = 4'b0100; t.pd = 16'h2000;
    vecs.push_back(t);
    vecs.push_back(mk(9'h01E, 9'd25, 0, 16'h0,    0, 20'h0,     1, 2, 0, 16'h0));
    vecs.push_back(mk(9'h01F, 9'd25, 1, 16'h0,    1, 20'h01000, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h020, 9'd25, 0, 16'h0,    0, 20'h0,     1, 2, 1, 16'h0));
    // line 26: sprite 0 waits, sprite 1 retries and ends with POS=CTL=0
    vecs.push_back(mk(9'h015, 9'd26, 1, 16'h0,    0, 20'h0,     0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h019, 9'd26, 1, 16'h0,    1, 20'h00000, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h01A, 9'd26, 0, 16'h0,    0, 20'h0,     1, 1, 0, 16'h0));
    vecs.push_back(mk(9'h01B, 9'd26, 1, 16'h0,    1, 20'h00001, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h01C, 9'd26, 0, 16'h0,    0, 20'h0,     1, 1, 1, 16'h0));
    vecs.push_back(mk(9'h019, 9'd27, 1, 16'h0,    0, 20'h0,     0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h01D, 9'd27, 1, 16'h0,    0, 20'h0,     0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h015, 9'h02F, 1, 16'h0,   0, 20'h0,     0, 0, 0, 16'h0));
    // lines 0x30, 0x31: image data, DATB first
    vecs.push_back(mk(9'h015, 9'h030, 1, 16'h0,    1, 20'h01002, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h016, 9'h030, 0, 16'hAAAA, 0, 20'h0,     1, 0, 3, 16'hAAAA));
    vecs.push_back(mk(9'h017, 9'h030, 1, 16'h0,    1, 20'h01003, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h018, 9'h030, 0, 16'h5555, 0, 20'h0,     1, 0, 2, 16'h5555));
    vecs.push_back(mk(9'h015, 9'h031, 1, 16'h0,    1, 20'h01004, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h016, 9'h031, 0, 16'h1111, 0, 20'h0,     1, 0, 3, 16'h1111));
    vecs.push_back(mk(9'h017, 9'h031, 1, 16'h0,    1, 20'h01005, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h018, 9'h031, 0, 16'h2222, 0, 20'h0,     1, 0, 2, 16'h2222));
    // line 0x32 (vstop): reuse, new pair gives vstart == vstop == 0x33
    vecs.push_back(mk(9'h015, 9'h032, 1, 16'h0,    1, 20'h01006, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h016, 9'h032, 0, 16'h3333, 0, 20'h0,     1, 0, 0, 16'h3333));
    vecs.push_back(mk(9'h017, 9'h032, 1, 16'h0,    1, 20'h01007, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h018, 9'h032, 0, 16'h3300, 0, 20'h0,     1, 0, 1, 16'h3300));
    // line 0x33: zero data lines, refetch POS/CTL -> 0/0 -> done
    vecs.push_back(mk(9'h015, 9'h033, 1, 16'h0,    1, 20'h01008, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h016, 9'h033, 0, 16'h0,    0, 20'h0,     1, 0, 0, 16'h0));
    vecs.push_back(mk(9'h017, 9'h033, 1, 16'h0,    1, 20'h01009, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h018, 9'h033, 0, 16'h0,    0, 20'h0,     1, 0, 1, 16'h0));
    vecs.push_back(mk(9'h015, 9'h034, 1, 16'h0,    0, 20'h0,     0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h017, 9'h034, 1, 16'h0,    0, 20'h0,     0, 0, 0, 16'h0));
    // next frame: dmaen freeze, pending write completes, pointer wrap
    vecs.push_back(mk(9'h000, 9'd25, 0, 16'h0,    0, 20'h0,     0, 0, 0, 16'h0));
    t = mk(9'h015, 9'd25, 1, 16'h0, 0, 20'h0, 0, 0, 0, 16'h0);
    t.dmaen = 1'b0;
    vecs.push_back(t);
    vecs.push_back(mk(9'h015, 9'd25, 1, 16'h0,    1, 20'h0100A, 0, 0, 0, 16'h0));
    t = mk(9'h016, 9'd25, 0, 16'h4444, 0, 20'h0, 1, 0, 0, 16'h4444);
    t.dmaen = 1'b0;
    vecs.push_back(t);
    t = mk(9'h017, 9'd25, 1, 16'h0, 0, 20'h0, 0, 0, 0, 16'h0);
    t.dmaen = 1'b0;
    vecs.push_back(t);
    vecs.push_back(mk(9'h021, 9'd25, 1, 16'h0,    1, 20'hFFFFF, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h022, 9'd25, 0, 16'h0001, 0, 20'h0,     1, 3, 0, 16'h0001));
    vecs.push_back(mk(9'h023, 9'd25, 1, 16'h0,    1, 20'h00000, 0, 0, 0, 16'h0));
    vecs.push_back(mk(9'h024, 9'd25, 0, 16'h0,    0, 20'h0,     1, 3, 1, 16'h0));

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset dma_req",  {31'd0, bus.dma_req},  32'd0);
    chk("reset spr_wr",   {31'd0, bus.spr_wr},   32'd0);
    chk("reset spr_data", {16'd0, bus.spr_data}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset on the acked edge of sprite 4 must cancel the capture
    @(negedge clk);
    bus.hpos = 9'h025; bus.vpos = 9'd25; bus.dmaen = 1'b1; bus.dma_ack = 1'b1;
    clk7_en = 1'b1; reset_n = 1'b0;
    #1;
    chk("rst req before edge", {31'd0, bus.dma_req}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1; clk7_en = 1'b0; bus.dma_ack = 1'b0;
    apply(mk(9'h026, 9'd25, 0, 16'hBEEF, 0, 20'h0, 0, 0, 0, 16'h0), 100);
    apply(mk(9'h025, 9'd25, 1, 16'h0,    0, 20'h0, 0, 0, 0, 16'h0), 101);
    apply(mk(9'h000, 9'd25, 0, 16'h0,    0, 20'h0, 0, 0, 0, 16'h0), 102);
    // clk7_en low: no request even on an owned slot
    @(negedge clk);
    bus.hpos = 9'h015; bus.vpos = 9'd25; bus.dma_ack = 1'b1; clk7_en = 1'b0;
    #1;
    chk("no req without clk7_en", {31'd0, bus.dma_req}, 32'd0);
    @(negedge clk);
    bus.dma_ack = 1'b0;
    // pointer was cleared by reset
    apply(mk(9'h015, 9'd25, 1, 16'h0, 1, 20'h00000, 0, 0, 0, 16'h0), 103);
    apply(mk(9'h016, 9'd25, 0, 16'h0, 0, 20'h0,     1, 0, 0, 16'h0), 104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
